// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: op codes and op-class helpers for the iterative mul/div unit.
// Shared by the unit, its step datapath, the core controller and benches.
package muldiv_unit_pkg;

  localparam int MD_OP_W = 4;

  typedef logic [MD_OP_W-1:0] md_op_t;

  localparam md_op_t MD_OP_MULT  = 4'd0;
  localparam md_op_t MD_OP_MULTU = 4'd1;
  localparam md_op_t MD_OP_DIV   = 4'd2;
  localparam md_op_t MD_OP_DIVU  = 4'd3;
  localparam md_op_t MD_OP_MADD  = 4'd4;
  localparam md_op_t MD_OP_MADDU = 4'd5;
  localparam md_op_t MD_OP_MSUB  = 4'd6;
  localparam md_op_t MD_OP_MSUBU = 4'd7;
  localparam md_op_t MD_OP_MTHI  = 4'd8;
  localparam md_op_t MD_OP_MTLO  = 4'd9;

  function automatic logic md_is_iter(md_op_t op);
    return op <= MD_OP_MSUBU;
  endfunction

  function automatic logic md_is_div(md_op_t op);
    return op == MD_OP_DIV || op == MD_OP_DIVU;
  endfunction

  function automatic logic md_is_signed(md_op_t op);
    return op == MD_OP_MULT || op == MD_OP_DIV ||
           op == MD_OP_MADD || op == MD_OP_MSUB;
  endfunction

  function automatic logic md_is_add(md_op_t op);
    return op == MD_OP_MADD || op == MD_OP_MADDU;
  endfunction

  function automatic logic md_is_sub(md_op_t op);
    return op == MD_OP_MSUB || op == MD_OP_MSUBU;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: core <-> mul/div unit bundle (start/op/a/b/abort in,
// ready/busy/done/hi/lo out). master = core, slave = unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
);
  logic             start;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, abort,
    input  ready, busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, abort,
    output ready, busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit_md_step.sv
// muldiv_unit_md_step: one combinational iteration, shift-add multiply
// (LSB first) or restoring divide (MSB first). acc/x in, next acc/x out.
module muldiv_unit_md_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   x_i,
  input  logic [WIDTH-1:0]   y_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0]   x_o
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   rem_n;
  logic [WIDTH+1:0] diff;
  logic             ge;

  always_comb begin
    addend = x_i[0] ? y_i : '0;
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    r_sh   = {acc_i[WIDTH-1:0], x_i[WIDTH-1]};
    diff   = {1'b0, r_sh} - {2'b00, y_i};
    ge     = ~diff[WIDTH+1];
    rem_n  = ge ? diff[WIDTH:0] : r_sh;
    if (is_div) begin
      acc_o = {{(WIDTH-1){1'b0}}, rem_n};
      x_o   = {x_i[WIDTH-2:0], ge};
    end else begin
      // carry lands in the top bit, low half collects shifted-out bits
      acc_o = {sum, acc_i[WIDTH-1:1]};
      x_o   = {1'b0, x_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative mul/div with HI/LO; clk, res_n, bus (slave:
// start/op/a/b/abort in, ready/busy/done/hi/lo out). Latency WIDTH+1.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = MD_OP_W
) (
  input  logic          clk,
  input  logic          res_n,
  muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [OP_W-1:0]  op_q;
  logic [W2-1:0]    acc_q, acc_s;
  logic [WIDTH-1:0] x_q, x_s, y_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             neg_q, rneg_q, divz_q, done_q;

  logic             take, iter, sgn, div_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [W2-1:0]    prod, res;
  logic [WIDTH-1:0] quo, rem;

  assign take   = bus.start & ~bus.abort & (state_q == S_IDLE);
  assign iter   = md_is_iter(bus.op);
  assign sgn    = md_is_signed(bus.op);
  assign div_in = md_is_div(bus.op);
  assign a_mag  = (sgn & bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag  = (sgn & bus.b[WIDTH-1]) ? -bus.b : bus.b;

  muldiv_unit_md_step #(.WIDTH(WIDTH)) u_step (
    .is_div (md_is_div(op_q)),
    .acc_i  (acc_q),
    .x_i    (x_q),
    .y_i    (y_q),
    .acc_o  (acc_s),
    .x_o    (x_s)
  );

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (take && iter) state_d = S_CALC;
      S_CALC: begin
        if (bus.abort)          state_d = S_IDLE;
        else if (cnt_q == '0)   state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ready = (state_q == S_IDLE);
    bus.busy  = (state_q != S_IDLE);
  end

  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  // divide by zero keeps the all-ones quotient the raw loop produces;
  // the remainder already equals |a| there, so its sign fix restores a
  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quo  = divz_q ? '1 : (neg_q ? -x_q : x_q);
    rem  = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    res  = prod;
    unique case (1'b1)
      md_is_div(op_q): res = {rem, quo};
      md_is_add(op_q): res = {hi_q, lo_q} + prod;
      md_is_sub(op_q): res = {hi_q, lo_q} - prod;
      default:         res = prod;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt_q  <= '0;
      op_q   <= '0;
      acc_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      divz_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (take) begin
          if (bus.op == MD_OP_MTHI) hi_q <= bus.a;
          if (bus.op == MD_OP_MTLO) lo_q <= bus.a;
          if (iter) begin
            op_q   <= bus.op;
            cnt_q  <= CW'(WIDTH - 1);
            acc_q  <= '0;
            x_q    <= div_in ? a_mag : b_mag;
            y_q    <= div_in ? b_mag : a_mag;
            neg_q  <= sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            rneg_q <= sgn & bus.a[WIDTH-1];
            divz_q <= (bus.b == '0);
          end
        end
        S_CALC: begin
          acc_q <= acc_s;
          x_q   <= x_s;
          cnt_q <= cnt_q - CW'(1);
        end
        S_FIX: if (!bus.abort) begin
          {hi_q, lo_q} <= res;
          done_q       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit with HI/LO result registers, used by the CPU core for MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU/MTHI/MTLO and read by MFHI/MFLO. It takes one shift-add or restoring-divide step per cycle and hands results back over a start/busy/done handshake. The core keeps executing unrelated instructions and stalls only on HI/LO access while busy. An abort input discards an in-flight operation when the core takes an exception.

## Interface
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- OP_W, 4: width of op code (`MD_OP_T`).
- clk  in  1  clock; all state changes on rising edge.
- res_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when `ready`=1.
- op  in  OP_W  operation, sampled with start.
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- b  in  WIDTH  rt operand (divisor / multiplier).
- abort  in  1  cancel in-flight operation.
- ready  out  1  idle, start will be accepted.
- busy  out  1  iterative operation in progress.
- done  out  1  one-cycle pulse when HI/LO are updated by an iterative op.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE: ready=1, busy=0. start with MTHI/MTLO writes `a` to HI/LO at that edge, stays IDLE, no done. start with any iterative op latches operands, sets counter=WIDTH-1, goes CALC. Unknown op: ignored.
- Signed ops (MULT, DIV, MADD, MSUB) take magnitudes; sign recorded at start, applied in FIX.
- CALC multiply: 2·WIDTH product accumulator, one multiplier bit per cycle, LSB first.
- CALC divide: restoring, one quotient bit per cycle, MSB first; remainder WIDTH+1 bits.
- Counter decrements each CALC cycle; at counter=0 go FIX.
- FIX: negate product/quotient if operand signs differ; remainder takes dividend's sign. MADD*/MSUB* add/subtract the 2·WIDTH product to/from {HI,LO} modulo 2^(2·WIDTH). Write HI/LO, pulse done, go IDLE.
- Results: MULT* → {HI,LO}=product; DIV* → LO=quotient, HI=remainder.
- Divide by zero: LO=all ones, HI=a (unsigned and signed); no trap.
- Signed overflow (−2^(WIDTH−1) / −1): LO=−2^(WIDTH−1), HI=0.
- start while busy: ignored (caller stalls on ready).
- abort in CALC or FIX: go IDLE next edge; HI/LO unchanged; no done. abort together with start in IDLE: start ignored.
- Reset (any time, mid-op included): state IDLE, HI=0, LO=0, counter=0, done=0, busy=0, ready=1.

## Timing
- Iterative op accepted at edge t: CALC for WIDTH cycles, FIX 1 cycle; done high and HI/LO new in cycle t+WIDTH+1 (WIDTH+1 cycles latency). ready reasserts same cycle as done.
- Back-to-back: next start accepted in the done cycle.
- MTHI/MTLO: value visible on hi/lo the cycle after acceptance.
- hi/lo are registered; they hold previous values throughout CALC.
- done never high two consecutive cycles.

## Structure
- Shared header `muldiv.vh`: `MD_OP_T` and op codes `MD_OP_MULT`, `MD_OP_MULTU`, `MD_OP_DIV`, `MD_OP_DIVU`, `MD_OP_MADD`, `MD_OP_MADDU`, `MD_OP_MSUB`, `MD_OP_MSUBU`, `MD_OP_MTHI`, `MD_OP_MTLO`; state encodings local.
- Controller decodes instructions to `MD_OP_T`; CPU core wires hi/lo into the register write mux and stalls on !ready.
- One sub-module natural: `md_step`, combinational single iteration (add-shift or subtract-compare), shared by multiply and divide datapaths.

## Test plan
- WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF → done at t+33, HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=−7 b=3 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; then MADD a=2 b=5 → LO=0xFFFFFFF5, HI=0xFFFFFFFF.
- DIV a=−7 b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0; DIVU a=5 b=0 → LO=0xFFFFFFFF, HI=5.
- MTHI a=0x1234 then start DIVU, assert abort in cycle 10 → no done, HI=0x1234, ready next cycle; start while busy → ignored, single done.
- res_n low mid-CALC → busy=0, ready=1, HI=LO=0 immediately; WIDTH=8 MULTU 0xFF·0xFF → done at t+9, HI=0xFE, LO=0x01.
